level_controller: RTL and testbench

- Game-level FSM for the whack-a-mole design. Sits upstream of display_controller and player.
- Owns the game-enable signal, the mole speed word, the level number, the round countdown timer and the final score.
- Consumes the running score from player; replaces the hard-wired speed constant and the raw SW[0] game enable in top.

---
 rtl/whack_pkg.sv | 17 +
 rtl/level_controller_tick_gen.sv | 26 ++
 rtl/level_controller.sv | 132 +++++++++++++
 tb/tb_level_controller.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/whack_pkg.sv
// Shared types and widths for the whack-a-mole game datapath.
package whack_pkg;

  localparam int unsigned SPEED_W       = 28;
  localparam int unsigned SCORE_W       = 8;
  localparam int unsigned LEVEL_W       = 3;
  localparam int unsigned TIME_W        = 7;
  localparam int unsigned DEFAULT_SPEED = 99999999;

  typedef enum logic [1:0] {StIdle, StPlay, StOver} state_e;

  function automatic logic [TIME_W-1:0] sat_time(input logic [TIME_W:0]   t,
                                                 input logic [TIME_W-1:0] lim);
    return (t > {1'b0, lim}) ? lim : t[TIME_W-1:0];
  endfunction

endpackage

// File: rtl/level_controller_tick_gen.sv
// Free-running one-second prescaler; held at zero while clear is high.
module tick_gen #(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_HZ - 1);

  logic [CntW-1:0] count_q;

  assign tick = !clear && (count_q == CntMax);

  always_ff @(posedge clock) begin
    if (reset || clear || tick) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/level_controller.sv
// Game-level FSM: owns game enable, mole speed, level, round timer and final score.
// Optional LEVEL_CONTROLLER_BONUS_TIME_EN adds BONUS_SECONDS to the timer on each level-up.
module level_controller
  import whack_pkg::*;
#(
  parameter int unsigned CLK_HZ           = 50000000,
  parameter int unsigned GAME_SECONDS     = 60,
  parameter int unsigned NUM_LEVELS       = 4,
  parameter int unsigned POINTS_PER_LEVEL = 5,
  parameter int unsigned BASE_SPEED       = DEFAULT_SPEED,
  parameter int unsigned SPEED_STEP       = 20000000,
  parameter int unsigned MIN_SPEED        = 25000000,
  parameter int unsigned BONUS_SECONDS    = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [SCORE_W-1:0] score,
  output logic               game,
  output logic [SPEED_W-1:0] speed,
  output logic [LEVEL_W-1:0] level,
  output logic [TIME_W-1:0]  time_left,
  output logic               level_up,
  output logic               game_over,
  output logic [SCORE_W-1:0] final_score
);

  typedef logic [SPEED_W:0] speed_ext_t;

  localparam logic [SPEED_W-1:0] BaseSpeed = SPEED_W'(BASE_SPEED);
  localparam logic [SPEED_W-1:0] MinSpeed  = SPEED_W'(MIN_SPEED);
  localparam logic [SPEED_W-1:0] StepSpeed = SPEED_W'(SPEED_STEP);
  localparam speed_ext_t         SpeedKnee = speed_ext_t'(MIN_SPEED + SPEED_STEP);
  localparam logic [TIME_W-1:0]  GameTime  = TIME_W'(GAME_SECONDS);
  localparam logic [TIME_W-1:0]  TimeOne   = TIME_W'(1);
  localparam logic [LEVEL_W-1:0] TopLevel  = LEVEL_W'(NUM_LEVELS - 1);
  localparam logic [9:0]         PointsW   = 10'(POINTS_PER_LEVEL);

  if (GAME_SECONDS < 1 || GAME_SECONDS > 127 || NUM_LEVELS < 2 || NUM_LEVELS > 8 ||
      POINTS_PER_LEVEL < 1 || POINTS_PER_LEVEL > 63 || BONUS_SECONDS > 127) begin : g_bad_params
    $error("level_controller: parameter out of range");
  end

  state_e              state_q;
  logic                clear, tick, lvl_up, timeout;
  logic [9:0]          threshold;
  logic [SPEED_W-1:0]  speed_dn;
  logic [TIME_W-1:0]   time_lvl;

  assign clear = (state_q != StPlay);

  tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_tick_gen (
    .clock(clock),
    .reset(reset),
    .clear(clear),
    .tick (tick)
  );

  always_comb begin
    threshold = (10'(level) + 10'd1) * PointsW;
    lvl_up    = (level < TopLevel) && ({2'b00, score} >= threshold);
    timeout   = tick && (time_left == TimeOne);
    speed_dn  = ({1'b0, speed} < SpeedKnee) ? MinSpeed : speed - StepSpeed;
`ifdef LEVEL_CONTROLLER_BONUS_TIME_EN
    // A tick landing on the level-up cycle is folded in before the bonus is added.
    time_lvl  = sat_time({1'b0, (tick && time_left > TimeOne) ? time_left - TimeOne : time_left}
                         + (TIME_W + 1)'(BONUS_SECONDS), GameTime);
`else
    time_lvl  = (tick && time_left > TimeOne) ? time_left - TimeOne : time_left;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      game        <= 1'b0;
      speed       <= BaseSpeed;
      level       <= '0;
      time_left   <= GameTime;
      level_up    <= 1'b0;
      game_over   <= 1'b0;
      final_score <= '0;
    end else begin
      level_up <= 1'b0;
      case (state_q)
        StIdle: begin
          game      <= start;
          game_over <= 1'b0;
          speed     <= BaseSpeed;
          level     <= '0;
          time_left <= GameTime;
          if (start) state_q <= StPlay;
        end
        StPlay: begin
          if (!start) begin
            state_q   <= StIdle;
            game      <= 1'b0;
            speed     <= BaseSpeed;
            level     <= '0;
            time_left <= GameTime;
          end else if (timeout) begin
            state_q     <= StOver;
            game        <= 1'b0;
            game_over   <= 1'b1;
            time_left   <= '0;
            final_score <= score;
          end else if (lvl_up) begin
            level     <= level + 1'b1;
            speed     <= speed_dn;
            level_up  <= 1'b1;
            time_left <= time_lvl;
          end else if (tick && time_left > TimeOne) begin
            time_left <= time_left - TimeOne;
          end
        end
        StOver: begin
          if (!start) begin
            state_q   <= StIdle;
            game_over <= 1'b0;
            speed     <= BaseSpeed;
            level     <= '0;
            time_left <= GameTime;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_level_controller.sv
// Scoreboard bench for level_controller: stimulus queues expected snapshots, a negedge monitor checks.
module tb_level_controller;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [7:0]  score;
  logic        game, level_up, game_over;
  logic [27:0] speed;
  logic [2:0]  level;
  logic [6:0]  time_left;
  logic [7:0]  final_score;

  typedef struct {
    string       name;
    logic        game;
    logic [27:0] speed;
    logic [2:0]  level;
    logic [6:0]  tl;
    logic        lu;
    logic        go;
    logic [7:0]  fs;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  bit   done     = 1'b0;

  always #5 clk = ~clk;

  level_controller #(
    .CLK_HZ          (10),
    .GAME_SECONDS    (5),
    .NUM_LEVELS      (4),
    .POINTS_PER_LEVEL(2),
    .BASE_SPEED      (100),
    .SPEED_STEP      (30),
    .MIN_SPEED       (25),
    .BONUS_SECONDS   (2)
  ) dut (
    .clock      (clk),
    .reset      (reset),
    .start      (start),
    .score      (score),
    .game       (game),
    .speed      (speed),
    .level      (level),
    .time_left  (time_left),
    .level_up   (level_up),
    .game_over  (game_over),
    .final_score(final_score)
  );

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      mon_e  = sb.pop_front();
      checks = checks + 1;
      if ({game, speed, level, time_left, level_up, game_over, final_score} !==
          {mon_e.game, mon_e.speed, mon_e.level, mon_e.tl, mon_e.lu, mon_e.go, mon_e.fs}) begin
        failures = failures + 1;
        $display("FAIL %s: got game=%0b speed=%0d level=%0d time_left=%0d level_up=%0b game_over=%0b final_score=%0d; want game=%0b speed=%0d level=%0d time_left=%0d level_up=%0b game_over=%0b final_score=%0d",
                 mon_e.name, game, speed, level, time_left, level_up, game_over, final_score,
                 mon_e.game, mon_e.speed, mon_e.level, mon_e.tl, mon_e.lu, mon_e.go, mon_e.fs);
      end
    end
    if (done) begin
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic g, input int sp, input int lv,
                            input int tl, input logic lu, input logic go, input int fs);
    exp_t e;
    e.name = nm;
    e.game = g;
    e.speed = 28'(sp);
    e.level = 3'(lv);
    e.tl = 7'(tl);
    e.lu = lu;
    e.go = go;
    e.fs = 8'(fs);
    sb.push_back(e);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    score = 8'd0;
    step();
    step();
    expect_out("reset", 0, 100, 0, 5, 0, 0, 0);
    checks = checks + 1;
    if (speed !== 28'd100) begin
      failures = failures + 1;
      $display("FAIL direct_reset_speed: got speed=%0d want 100", speed);
    end

    // 1: full round timeout with score 1
    reset = 1'b0;
    start = 1'b1;
    score = 8'd1;
    for (int k = 1; k <= 50; k++) begin
      step();
      expect_out("round_timer", 1, 100, 0, 5 - (k - 1) / 10, 0, 0, 0);
    end
    step();
    expect_out("timeout_over", 0, 100, 0, 0, 0, 1, 1);
    checks = checks + 1;
    if (game_over !== 1'b1 || final_score !== 8'd1) begin
      failures = failures + 1;
      $display("FAIL direct_timeout: got game_over=%0b final_score=%0d want 1 1",
               game_over, final_score);
    end
    step();
    expect_out("over_hold_1", 0, 100, 0, 0, 0, 1, 1);
    step();
    expect_out("over_hold_2", 0, 100, 0, 0, 0, 1, 1);
    start = 1'b0;
    step();
    expect_out("over_to_idle", 0, 100, 0, 5, 0, 0, 1);

    // 2: stepped score climbs levels, speed floors at 25
    score = 8'd0;
    start = 1'b1;
    step();
    expect_out("play_entry", 1, 100, 0, 5, 0, 0, 1);
    score = 8'd2;
    step();
    expect_out("lvl1_pulse", 1, 70, 1, 5, 1, 0, 1);
    step();
    expect_out("lvl1_hold", 1, 70, 1, 5, 0, 0, 1);
    score = 8'd4;
    step();
    expect_out("lvl2_pulse", 1, 40, 2, 5, 1, 0, 1);
    step();
    expect_out("lvl2_hold", 1, 40, 2, 5, 0, 0, 1);
    score = 8'd6;
    step();
    expect_out("lvl3_floor", 1, 25, 3, 5, 1, 0, 1);
    checks = checks + 1;
    if (speed !== 28'd25) begin
      failures = failures + 1;
      $display("FAIL direct_floor: got speed=%0d want 25", speed);
    end
    step();
    expect_out("lvl3_hold", 1, 25, 3, 5, 0, 0, 1);
    score = 8'd8;
    step();
    expect_out("top_level_a", 1, 25, 3, 5, 0, 0, 1);
    step();
    expect_out("top_level_b", 1, 25, 3, 5, 0, 0, 1);
    start = 1'b0;
    score = 8'd0;
    step();
    expect_out("abort_top", 0, 100, 0, 5, 0, 0, 1);

    // 3: score jump 0->6 climbs one level per cycle
    start = 1'b1;
    step();
    expect_out("jump_entry", 1, 100, 0, 5, 0, 0, 1);
    score = 8'd6;
    step();
    expect_out("jump_l1", 1, 70, 1, 5, 1, 0, 1);
    step();
    expect_out("jump_l2", 1, 40, 2, 5, 1, 0, 1);
    step();
    expect_out("jump_l3", 1, 25, 3, 5, 1, 0, 1);
    checks = checks + 1;
    if (level !== 3'd3 || level_up !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL direct_jump: got level=%0d level_up=%0b want 3 1", level, level_up);
    end
    step();
    expect_out("jump_settle", 1, 25, 3, 5, 0, 0, 1);
    start = 1'b0;
    score = 8'd0;
    step();
    expect_out("jump_abort", 0, 100, 0, 5, 0, 0, 1);

    // 5: abort at level 2
    start = 1'b1;
    step();
    expect_out("abort_entry", 1, 100, 0, 5, 0, 0, 1);
    score = 8'd4;
    step();
    expect_out("abort_l1", 1, 70, 1, 5, 1, 0, 1);
    step();
    expect_out("abort_l2", 1, 40, 2, 5, 1, 0, 1);
    start = 1'b0;
    step();
    expect_out("abort_idle", 0, 100, 0, 5, 0, 0, 1);

    // 4: level-up coincides with timeout; timeout wins
    score = 8'd0;
    start = 1'b1;
    step();
    expect_out("tie_entry", 1, 100, 0, 5, 0, 0, 1);
    for (int k = 2; k <= 50; k++) step();
    expect_out("tie_last_sec", 1, 100, 0, 1, 0, 0, 1);
    score = 8'd2;
    step();
    expect_out("tie_timeout", 0, 100, 0, 0, 0, 1, 2);
    checks = checks + 1;
    if (level !== 3'd0 || level_up !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL direct_tie: got level=%0d level_up=%0b want 0 0", level, level_up);
    end
    start = 1'b0;
    score = 8'd0;
    step();
    expect_out("tie_idle", 0, 100, 0, 5, 0, 0, 2);

    // 6: level-up timer effect, then reset mid-PLAY
    start = 1'b1;
    step();
    expect_out("bonus_entry", 1, 100, 0, 5, 0, 0, 2);
    for (int k = 2; k <= 31; k++) step();
    expect_out("bonus_tl2", 1, 100, 0, 2, 0, 0, 2);
    score = 8'd2;
    step();
`ifdef LEVEL_CONTROLLER_BONUS_TIME_EN
    expect_out("bonus_add", 1, 70, 1, 4, 1, 0, 2);
`else
    expect_out("bonus_add", 1, 70, 1, 2, 1, 0, 2);
`endif
    score = 8'd4;
    step();
`ifdef LEVEL_CONTROLLER_BONUS_TIME_EN
    expect_out("bonus_sat", 1, 40, 2, 5, 1, 0, 2);
`else
    expect_out("bonus_sat", 1, 40, 2, 2, 1, 0, 2);
`endif
    score = 8'd6;
    reset = 1'b1;
    step();
    expect_out("reset_mid_play", 0, 100, 0, 5, 0, 0, 0);
    checks = checks + 1;
    if (game !== 1'b0 || final_score !== 8'd0) begin
      failures = failures + 1;
      $display("FAIL direct_reset_mid: got game=%0b final_score=%0d want 0 0",
               game, final_score);
    end
    reset = 1'b0;
    start = 1'b0;
    step();
    expect_out("post_reset_idle", 0, 100, 0, 5, 0, 0, 0);

    done = 1'b1;
    repeat (5) @(posedge clk);
    $display("FAIL monitor: summary not reached, got done=%0b want finish", done);
    $fatal(1, "monitor did not finish");
  end

endmodule
